// File: rtl/rom_loader_pkg.sv
// Shared widths, polarities and helpers for the boot-time ROM loader.
package rom_loader_pkg;

    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam int          MEM_ADDR_W    = 32;
    localparam int          MEM_W         = 32;
    localparam int          LOADER_LEN_W  = 32;
    localparam int          ROM_NUM       = 4096;

    // Byte address of word `idx` in a word-aligned region starting at `base`.
    function automatic logic [MEM_ADDR_W-1:0] word_addr(
        input logic [MEM_ADDR_W-1:0]   base,
        input logic [LOADER_LEN_W-1:0] idx
    );
        return base + {idx[MEM_ADDR_W-3:0], 2'b00};
    endfunction

endpackage

// File: rtl/rom_loader_byte_pack.sv
// Four-byte little-endian pack register: byte k of a word lands in bits [8k+7:8k].
module loader_byte_pack
    import rom_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [7:0]       byte_in,
    output logic [MEM_W-1:0] word_next,
    output logic             word_full
);

    logic [1:0]       idx;
    logic [MEM_W-1:0] word_q;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || clear) begin
            idx    <= 2'd0;
            word_q <= ZERO_WORD;
        end else if (load) begin
            idx    <= idx + 2'd1;
            word_q <= word_next;
        end
    end

    // word_next already contains the byte being transferred, so the owner can
    // capture the complete word on the same edge as the fourth byte.
    always_comb begin
        word_next = word_q;
        word_next[8*idx +: 8] = byte_in;
        word_full = load && (idx == 2'd3);
    end

endmodule

// File: rtl/rom_loader.sv
// Boot loader: packs a host byte stream into words and writes them to the instruction ROM.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter logic [MEM_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int                    ROM_WORDS = ROM_NUM
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [LOADER_LEN_W-1:0] len_i,
    input  logic                    byte_valid_i,
    input  logic [7:0]              byte_i,
    output logic                    byte_ready_o,
    output logic                    we_o,
    output logic [MEM_ADDR_W-1:0]   addr_o,
    output logic [MEM_W-1:0]        data_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [LOADER_LEN_W-1:0] len_q;
    logic [LOADER_LEN_W-1:0] count_q;
    logic                    len_err;
    logic                    start_ok;
    logic                    xfer;
    logic                    word_full;
    logic [MEM_W-1:0]        word_next;

    assign len_err  = len_i > LOADER_LEN_W'(ROM_WORDS);
    assign start_ok = (state == IDLE) && start_i && !len_err;
    assign xfer     = (state == COLLECT) && byte_valid_i;

    loader_byte_pack u_pack (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .load      (xfer),
        .byte_in   (byte_i),
        .word_next (word_next),
        .word_full (word_full)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = (len_i == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (word_full) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = (count_q + 1'b1 == len_q) ? DONE : COLLECT;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address and data are captured with the fourth byte so they are stable
    // throughout the WRITE cycle and keep the last write's values afterwards.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state   <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            addr_o  <= ZERO_WORD;
            data_o  <= ZERO_WORD;
            err_o   <= 1'b0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                len_q   <= len_i;
                count_q <= '0;
                err_o   <= 1'b0;
            end else if (state == IDLE && start_i) begin
                err_o <= 1'b1;
            end
            if (word_full) begin
                addr_o <= word_addr(BASE_ADDR, count_q);
                data_o <= word_next;
            end
            if (state == WRITE) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign byte_ready_o = (state == COLLECT);
    assign we_o         = (state == WRITE) ? WRITE_ENABLE : WRITE_DISABLE;
    assign busy_o       = (state == COLLECT) || (state == WRITE);
    assign done_o       = (state == DONE);

endmodule
